if_spi_ctrl: RTL and testbench
==============================

Name: if_spi_ctrl

Overview:
- Byte-stream to SPI master bridge.
- Host bytes are paired into 16-bit words, queued in an input FIFO, and sent MSB-first as 16-bit SPI transfers (mode 0).
- Each transfer's captured MISO word is split into two bytes and queued in an output FIFO, which the host drains with rd_req.
- Sits between the host byte bus and one external SPI slave; the my_* ports expose internal handshakes for verification.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period (≥2).
- FIFO_DEPTH, 16: input FIFO depth in 16-bit words; output FIFO depth is 2*FIFO_DEPTH bytes (power of two).

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- in_data  in  8  host write byte
- in_ena  in  1  in_data valid this cycle
- rd_req  in  1  host pop request for output FIFO
- miso  in  1  SPI data from slave
- cs  out  1  SPI chip select, active low
- sclk  out  1  SPI clock, idle low
- mosi  out  1  SPI data to slave
- have_msg  out  1  output FIFO not empty
- out_data  out  8  popped byte
- out_ena  out  1  out_data valid strobe
- my_busy  out  1  transfer engine active
- my_empty  out  1  input FIFO empty
- my_fifo_q  out  16  input FIFO head word (show-ahead)
- my_go  out  1  one-cycle transfer start / input FIFO pop
- my_datao  out  16  last received word
- my_done  out  1  one-cycle transfer complete
- my_datao_ena  out  1  received-word write strobe, equals my_done

Behaviour:
- Reset: n_rst low asynchronously clears both FIFOs and the pairing register, and aborts any transfer. Output values during reset: cs=1, sclk=0, mosi=0, have_msg=0, out_data=0, out_ena=0, my_busy=0, my_empty=1, my_go=0, my_done=0, my_datao=0, my_datao_ena=0. Reset mid-transfer drops the word being transferred.
- Pairing:
  - First in_ena byte is latched as the high byte; the second forms {high,low}.
  - The word is written to the input FIFO on the following clk.
  - If the input FIFO is full, the completed word is discarded.
  - An odd trailing byte waits indefinitely for its partner.
- Start: my_go=1 for exactly one cycle when !my_busy, !my_empty, and the output FIFO has ≥2 free bytes. On that cycle my_fifo_q is loaded into the TX shifter and popped. my_busy rises the next cycle.
- FSM states: IDLE → SETUP → SHIFT → HOLD → DONE → IDLE.
  - SETUP: cs=0, mosi=bit15, sclk low for CLK_DIV cycles.
  - SHIFT: 16 sclk periods of 2*CLK_DIV clks each.
    - Rising edge: sample miso into the RX shifter, MSB first.
    - Falling edge: shift the next bit onto mosi.
  - HOLD: after the 16th falling edge, hold cs low for CLK_DIV cycles, then drive cs=1.
  - DONE:
    - my_done=my_datao_ena=1 for one cycle.
    - my_datao is updated to the RX word and holds until the next DONE.
    - my_busy falls.
  - IDLE: minimum cs-high gap of CLK_DIV cycles before the next my_go.
- Output FIFO: a received word is written as high byte then low byte on two consecutive cycles after DONE; have_msg tracks non-empty.
- Read: rd_req with have_msg=1 pops one byte; out_data updates and out_ena=1 on the next cycle. rd_req while empty is ignored (out_ena=0). out_data holds its value between pops.
- Simultaneous write and read on either FIFO is supported in the same cycle.

Optional Feature:
- IF_SPI_LOOPBACK_EN defined: the RX shifter samples the internal mosi instead of the miso pin, so the received word equals the transmitted word. cs, sclk and mosi still toggle.
- Not defined: miso is used.

Decomposition:
- Package if_spi_pkg holds: BYTE_W=8, WORD_W=16, the FSM state enum (IDLE, SETUP, SHIFT, HOLD, DONE), and the default CLK_DIV.
- One sub-module, if_spi_fifo: parameterised width/depth, show-ahead synchronous FIFO. It is instanced as input (16×FIFO_DEPTH) and output (8×2*FIFO_DEPTH).

Test Plan:
- Reset: hold n_rst=0 → cs=1, sclk=0, have_msg=0, my_empty=1, out_ena=0.
- Write bytes 01..06, one per clk →
  - three transfers with mosi words 0x0102, 0x0304, 0x0506, MSB first;
  - cs low across exactly 16 sclk rising edges per transfer;
  - one my_go and one my_done per word.
- Drive miso=0xA55A per transfer → my_datao=0xA55A on my_done. After all transfers, rd_req for 8 cycles → out_ena for exactly 6 cycles with bytes A5,5A repeating; have_msg falls after the 6th pop.
- Random miso plus a bit-accurate model → each my_datao matches the bits sampled on sclk rising edges; sclk period = 2*CLK_DIV clks.
- Fill the output FIFO to 2*FIFO_DEPTH-1 bytes → my_go is withheld while the input FIFO is non-empty; a single rd_req releases it.
- Assert n_rst mid-SHIFT → cs=1 and sclk=0 immediately; after release, no my_done for the aborted word.

Source files
------------

// File: rtl/if_spi_pkg.sv
// Shared widths, transfer FSM encoding and default sclk divider for the byte-stream SPI bridge.
package if_spi_pkg;

   localparam int BYTE_W      = 8;
   localparam int WORD_W      = 16;
   localparam int CLK_DIV_DEF = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } spi_state_e;

endpackage

// File: rtl/if_spi_fifo.sv
// Show-ahead synchronous FIFO: head word on rd_dat with no read latency; push and pop may share a cycle.
// Pops while empty are ignored; pushes while full are dropped unless a pop frees the slot that cycle.
module if_spi_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    wr_vld,
   input  logic [WIDTH-1:0]        wr_dat,
   input  logic                    rd_vld,
   output logic [WIDTH-1:0]        rd_dat,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // DEPTH is a power of two, so the count MSB alone flags full
   assign empty  = (count == '0);
   assign full   = count[AW];
   assign do_rd  = rd_vld && !empty;
   assign do_wr  = wr_vld && (!full || do_rd);
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

endmodule

// File: rtl/if_spi_ctrl.sv
// Byte-pair to 16-bit SPI mode-0 master; defining IF_SPI_LOOPBACK_EN feeds the internal mosi into the RX shifter.
// Word queued 1 clk after its 2nd byte, pop data 1 clk after rd_req; transfers stall until the output FIFO has 2 free bytes.
module if_spi_ctrl
   import if_spi_pkg::*;
#(
   parameter int CLK_DIV    = CLK_DIV_DEF,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [BYTE_W-1:0]   in_data,
   input  logic                in_ena,
   input  logic                rd_req,
   input  logic                miso,
   output logic                cs,
   output logic                sclk,
   output logic                mosi,
   output logic                have_msg,
   output logic [BYTE_W-1:0]   out_data,
   output logic                out_ena,
   output logic                my_busy,
   output logic                my_empty,
   output logic [WORD_W-1:0]   my_fifo_q,
   output logic                my_go,
   output logic [WORD_W-1:0]   my_datao,
   output logic                my_done,
   output logic                my_datao_ena
);

   localparam int OUT_DEPTH = 2 * FIFO_DEPTH;
   localparam int ICW       = $clog2(FIFO_DEPTH) + 1;
   localparam int OCW       = $clog2(OUT_DEPTH) + 1;
   localparam int CW        = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  DIV_FULL  = CW'(CLK_DIV);
   localparam logic [OCW-1:0] OUT_LIMIT = OCW'(OUT_DEPTH - 2);

   // byte pairing
   logic              hi_vld;
   logic [BYTE_W-1:0] hi_byte;
   logic              pair_vld;
   logic [WORD_W-1:0] pair_dat;

   // input FIFO
   logic [WORD_W-1:0] in_head;
   logic              in_empty;
   logic              in_full;
   logic [ICW-1:0]    in_count;

   // output FIFO
   logic              ow_hi;
   logic              ow_lo;
   logic              out_wr_vld;
   logic [BYTE_W-1:0] out_wr_dat;
   logic [BYTE_W-1:0] out_head;
   logic              out_empty;
   logic              out_full;
   logic [OCW-1:0]    out_count;
   logic [OCW-1:0]    out_pend;

   // transfer engine
   spi_state_e        state;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     gap;
   logic [3:0]        bit_cnt;
   logic [WORD_W-1:0] tx_sh;
   logic [WORD_W-1:0] rx_sh;
   logic              rx_bit;
   logic              unused_sigs;

`ifdef IF_SPI_LOOPBACK_EN
   assign rx_bit      = mosi;
   assign unused_sigs = ^{in_full, in_count, out_full, miso};
`else
   assign rx_bit      = miso;
   assign unused_sigs = ^{in_full, in_count, out_full};
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hi_vld   <= 1'b0;
         hi_byte  <= '0;
         pair_vld <= 1'b0;
         pair_dat <= '0;
      end else begin
         pair_vld <= 1'b0;
         if (in_ena) begin
            if (hi_vld) begin
               pair_vld <= 1'b1;
               pair_dat <= {hi_byte, in_data};
               hi_vld   <= 1'b0;
            end else begin
               hi_byte  <= in_data;
               hi_vld   <= 1'b1;
            end
         end
      end
   end

   if_spi_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_in_fifo (
      .clk    (clk),
      .n_rst  (n_rst),
      .wr_vld (pair_vld),
      .wr_dat (pair_dat),
      .rd_vld (my_go),
      .rd_dat (in_head),
      .empty  (in_empty),
      .full   (in_full),
      .count  (in_count)
   );

   // bytes of the last word still on their way into the output FIFO count as occupied
   assign out_pend = OCW'({ow_hi, ow_lo});

   assign my_go        = (state == IDLE) && (gap == DIV_FULL) && !in_empty
                         && ((out_count + out_pend) <= OUT_LIMIT);
   assign my_busy      = (state != IDLE);
   assign my_done      = (state == DONE);
   assign my_datao_ena = my_done;
   assign my_empty     = in_empty;
   assign my_fifo_q    = in_empty ? '0 : in_head;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         gap      <= DIV_FULL;
         bit_cnt  <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         cs       <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         my_datao <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gap != DIV_FULL) gap <= gap + CW'(1);
               if (my_go) begin
                  state   <= SETUP;
                  cs      <= 1'b0;
                  mosi    <= in_head[WORD_W-1];
                  tx_sh   <= in_head;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end
            end
            SETUP, SHIFT: begin
               cnt <= cnt + CW'(1);
               if (cnt == DIV_LAST) begin
                  cnt  <= '0;
                  sclk <= ~sclk;
                  if (!sclk) begin
                     rx_sh <= {rx_sh[WORD_W-2:0], rx_bit};
                     state <= SHIFT;
                  end else if (bit_cnt == 4'd15) begin
                     state <= HOLD;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     tx_sh   <= tx_sh << 1;
                     mosi    <= tx_sh[WORD_W-2];
                  end
               end
            end
            HOLD: begin
               cnt <= cnt + CW'(1);
               if (cnt == DIV_LAST) begin
                  cnt      <= '0;
                  cs       <= 1'b1;
                  mosi     <= 1'b0;
                  my_datao <= rx_sh;
                  state    <= DONE;
               end
            end
            DONE: begin
               // DONE is the first cs-high cycle of the inter-transfer gap
               gap   <= CW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ow_hi <= 1'b0;
         ow_lo <= 1'b0;
      end else begin
         ow_hi <= my_done;
         ow_lo <= ow_hi;
      end
   end

   assign out_wr_vld = ow_hi || ow_lo;
   assign out_wr_dat = ow_hi ? my_datao[WORD_W-1:BYTE_W] : my_datao[BYTE_W-1:0];
   assign have_msg   = !out_empty;

   if_spi_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk    (clk),
      .n_rst  (n_rst),
      .wr_vld (out_wr_vld),
      .wr_dat (out_wr_dat),
      .rd_vld (rd_req),
      .rd_dat (out_head),
      .empty  (out_empty),
      .full   (out_full),
      .count  (out_count)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_data <= '0;
         out_ena  <= 1'b0;
      end else begin
         out_ena <= rd_req && !out_empty;
         if (rd_req && !out_empty) out_data <= out_head;
      end
   end

endmodule

// File: tb/tb_if_spi_ctrl.sv
// Bench for if_spi_ctrl: vector table plus SPI slave model; expectations queue at stimulus time and are checked on DUT output.
module tb_if_spi_ctrl;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;

   logic        clk     = 1'b0;
   logic        n_rst   = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ena  = 1'b0;
   logic        rd_req  = 1'b0;
   logic        miso    = 1'b0;
   logic        cs, sclk, mosi, have_msg, out_ena, my_busy, my_empty, my_go;
   logic        my_done, my_datao_ena;
   logic [7:0]  out_data;
   logic [15:0] my_fifo_q, my_datao;

   always #5 clk = ~clk;

   if_spi_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .in_data      (in_data),
      .in_ena       (in_ena),
      .rd_req       (rd_req),
      .miso         (miso),
      .cs           (cs),
      .sclk         (sclk),
      .mosi         (mosi),
      .have_msg     (have_msg),
      .out_data     (out_data),
      .out_ena      (out_ena),
      .my_busy      (my_busy),
      .my_empty     (my_empty),
      .my_fifo_q    (my_fifo_q),
      .my_go        (my_go),
      .my_datao     (my_datao),
      .my_done      (my_done),
      .my_datao_ena (my_datao_ena)
   );

   typedef struct {
      logic [15:0] tx;
      logic [15:0] rxw;
   } vec_t;

   vec_t        vt [12];
   logic [15:0] tx_q [$];
   logic [15:0] miso_q [$];
   logic [15:0] rx_q [$];
   logic [15:0] samp_q [$];
   logic [7:0]  byte_q [$];

   int n_chk = 0, n_fail = 0;
   int go_cnt = 0, done_cnt = 0, ena_cnt = 0, cyc = 0;
   int g0, d0, e0, n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v);
      tx_q.push_back(v.tx);
      miso_q.push_back(v.rxw);
      rx_q.push_back(v.rxw);
      byte_q.push_back(v.rxw[15:8]);
      byte_q.push_back(v.rxw[7:0]);
      in_data = v.tx[15:8];
      in_ena  = 1'b1;
      tick();
      in_data = v.tx[7:0];
      tick();
      in_ena  = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(done_cnt >= target), 1);
   endtask

   task automatic drain(input int cycles);
      rd_req = 1'b1;
      repeat (cycles) tick();
      rd_req = 1'b0;
      repeat (2) tick();
   endtask

   // SPI slave model and output monitors
   logic        cs_p = 1'b1, sclk_p = 1'b0;
   logic [15:0] mosi_w = 16'h0, samp_w = 16'h0, miso_w = 16'h0;
   int          rises = 0, last_rise = 0, miso_idx = 0;

   always @(negedge clk) begin
      cyc++;
      if (!n_rst) begin
         rises = 0;
      end else begin
         if (cs_p && !cs) begin
            rises    = 0;
            mosi_w   = 16'h0;
            samp_w   = 16'h0;
            miso_w   = (miso_q.size() > 0) ? miso_q.pop_front() : 16'h0;
            miso_idx = 15;
            miso     = miso_w[15];
         end
         if (!cs && !sclk_p && sclk) begin
            if (rises > 0) check("sclk_period", 32'(cyc - last_rise), 2 * CLK_DIV);
            last_rise = cyc;
            rises++;
            mosi_w = {mosi_w[14:0], mosi};
            samp_w = {samp_w[14:0], miso};
         end
         if (!cs && sclk_p && !sclk && miso_idx > 0) begin
            miso_idx--;
            miso = miso_w[miso_idx];
         end
         if (!cs_p && cs) begin
            check("rises_per_cs", 32'(rises), 16);
            if (tx_q.size() > 0) check("mosi_word", {16'h0, mosi_w}, {16'h0, tx_q.pop_front()});
            else check("mosi_unexpected_xfer", 1, 0);
            samp_q.push_back(samp_w);
         end
         if (my_go) go_cnt++;
         if (my_done) begin
            done_cnt++;
            check("datao_ena", {31'h0, my_datao_ena}, 1);
            if (rx_q.size() > 0) check("datao", {16'h0, my_datao}, {16'h0, rx_q.pop_front()});
            else check("datao_unexpected_done", 1, 0);
            if (samp_q.size() > 0) check("datao_vs_sampled", {16'h0, my_datao}, {16'h0, samp_q.pop_front()});
         end
         if (out_ena) begin
            ena_cnt++;
            if (byte_q.size() > 0) check("out_data", {24'h0, out_data}, {24'h0, byte_q.pop_front()});
            else check("out_ena_unexpected", 1, 0);
         end
      end
      cs_p   = cs;
      sclk_p = sclk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{16'h0102, 16'hA55A};
      vt[1] = '{16'h0304, 16'hA55A};
      vt[2] = '{16'h0506, 16'hA55A};
      for (int i = 3; i < 12; i++) vt[i] = '{16'($urandom), 16'($urandom)};

      // reset values
      repeat (3) tick();
      check("rst_cs", {31'h0, cs}, 1);
      check("rst_sclk", {31'h0, sclk}, 0);
      check("rst_mosi", {31'h0, mosi}, 0);
      check("rst_have_msg", {31'h0, have_msg}, 0);
      check("rst_my_empty", {31'h0, my_empty}, 1);
      check("rst_out_ena", {31'h0, out_ena}, 0);
      check("rst_out_data", {24'h0, out_data}, 0);
      check("rst_busy", {31'h0, my_busy}, 0);
      check("rst_go", {31'h0, my_go}, 0);
      check("rst_done", {31'h0, my_done}, 0);
      check("rst_datao", {16'h0, my_datao}, 0);
      n_rst = 1'b1;
      tick();

      // bytes 01..06 back to back, miso A55A
      g0 = go_cnt; d0 = done_cnt;
      for (int i = 0; i < 3; i++) send(vt[i]);
      wait_done(d0 + 3, 2000, "tableA_done_timeout");
      repeat (10) tick();
      check("tableA_go_count", 32'(go_cnt - g0), 3);
      check("tableA_done_count", 32'(done_cnt - d0), 3);
      check("tableA_have_msg", {31'h0, have_msg}, 1);
      e0 = ena_cnt;
      rd_req = 1'b1;
      repeat (8) tick();
      rd_req = 1'b0;
      tick();
      check("tableA_pop_count", 32'(ena_cnt - e0), 6);
      check("tableA_have_msg_drained", {31'h0, have_msg}, 0);

      // random words and miso
      d0 = done_cnt; e0 = ena_cnt;
      for (int i = 3; i < 7; i++) send(vt[i]);
      wait_done(d0 + 4, 3000, "tableB_done_timeout");
      repeat (10) tick();
      drain(12);
      check("tableB_pop_count", 32'(ena_cnt - e0), 8);

      // output FIFO backpressure
      d0 = done_cnt; e0 = ena_cnt;
      for (int i = 7; i < 12; i++) send(vt[i]);
      wait_done(d0 + 4, 3000, "full_done_timeout");
      repeat (10) tick();
      check("full_have_msg", {31'h0, have_msg}, 1);
      check("full_in_not_empty", {31'h0, my_empty}, 0);
      g0 = go_cnt;
      repeat (40) tick();
      check("go_withheld_full", 32'(go_cnt - g0), 0);
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      repeat (40) tick();
      check("go_withheld_one_free", 32'(go_cnt - g0), 0);
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      n = 0;
      while (go_cnt == g0 && n < 30) begin tick(); n++; end
      check("go_released", 32'(go_cnt - g0), 1);
      wait_done(d0 + 5, 1000, "full_last_done_timeout");
      repeat (10) tick();
      drain(12);
      check("full_pop_count", 32'(ena_cnt - e0), 10);

      // odd trailing byte waits for its partner
      g0 = go_cnt;
      in_data = 8'h77; in_ena = 1'b1; tick(); in_ena = 1'b0;
      repeat (40) tick();
      check("odd_byte_empty", {31'h0, my_empty}, 1);
      check("odd_byte_no_go", 32'(go_cnt - g0), 0);

      // reset mid-SHIFT
      tx_q.push_back(16'h7712);
      miso_q.push_back(16'hFFFF);
      in_data = 8'h12; in_ena = 1'b1; tick();
      in_data = 8'h34; tick(); in_ena = 1'b0;
      n = 0;
      while (!sclk && n < 500) begin tick(); n++; end
      check("reached_shift", {31'h0, sclk}, 1);
      check("busy_in_shift", {31'h0, my_busy}, 1);
      repeat (3) tick();
      #2 n_rst = 1'b0;
      #1;
      check("abort_cs", {31'h0, cs}, 1);
      check("abort_sclk", {31'h0, sclk}, 0);
      check("abort_busy", {31'h0, my_busy}, 0);
      check("abort_mosi", {31'h0, mosi}, 0);
      check("abort_datao", {16'h0, my_datao}, 0);
      tx_q.delete(); miso_q.delete(); rx_q.delete(); samp_q.delete(); byte_q.delete();
      d0 = done_cnt;
      repeat (3) tick();
      n_rst = 1'b1;
      repeat (200) tick();
      check("no_done_after_abort", 32'(done_cnt - d0), 0);
      check("no_msg_after_abort", {31'h0, have_msg}, 0);
      check("empty_after_abort", {31'h0, my_empty}, 1);

      // pairing restarts cleanly after reset
      send('{16'hABCD, 16'h3C3C});
      wait_done(d0 + 1, 1000, "post_reset_done_timeout");
      repeat (10) tick();
      drain(6);
      check("bytes_all_popped", 32'(byte_q.size()), 0);
      check("words_all_sent", 32'(tx_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
